// File: rtl/bitrev_pkg.sv
// Shared mode codes and FSM encoding for the bit-reversal engine.
package bitrev_pkg;

   localparam logic [1:0] MODE_BIT     = 2'd0;
   localparam logic [1:0] MODE_BYTE    = 2'd1;
   localparam logic [1:0] MODE_BITBYTE = 2'd2;
   localparam logic [1:0] MODE_PASS    = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/bitrev_index_map.sv
// Combinational map from result bit position j to its source bit index.
// Byte-based modes fall back to full reversal when WIDTH is not a byte multiple.
module bitrev_index_map
   import bitrev_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IW = $clog2(WIDTH)
) (
   input  logic [1:0]    mode,
   input  logic [IW-1:0] j,
   output logic [IW-1:0] src_idx
);

   localparam bit BYTE_ALIGNED = (WIDTH % 8) == 0;

   int unsigned w_j;
   int unsigned w_s;

   always_comb begin
      w_j = 32'(j);
      w_s = w_j;
      case (mode)
         MODE_BIT:     w_s = WIDTH - 1 - w_j;
         MODE_BYTE:    w_s = BYTE_ALIGNED ? (WIDTH / 8 - 1 - w_j / 8) * 8 + w_j % 8
                                          : WIDTH - 1 - w_j;
         MODE_BITBYTE: w_s = BYTE_ALIGNED ? 8 * (w_j / 8) + 7 - w_j % 8
                                          : WIDTH - 1 - w_j;
         default:      w_s = w_j;
      endcase
      src_idx = IW'(w_s);
   end

endmodule

// File: rtl/bitrev_engine.sv
// Handshaked streaming bit permuter producing BITS_PER_CYCLE result bits per clock.
// Optional BITREV_PALINDROME_EN adds out_palin (result equals source word).
module bitrev_engine
   import bitrev_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
`ifdef BITREV_PALINDROME_EN
   ,
   output logic             out_palin
`endif
);

   localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned IW = $clog2(WIDTH);

   state_t                    r_state;
   logic [WIDTH-1:0]          r_src;
   logic [1:0]                r_mode;
   logic [WIDTH-1:0]          r_result;
   logic [CW-1:0]             r_count;
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic [WIDTH-1:0]          r_out_data;
   logic                      r_busy;
   logic [BITS_PER_CYCLE-1:0] w_slice;
   logic [WIDTH-1:0]          w_next_result;
   logic                      w_last;

   // One index mapper per result bit produced this cycle.
   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_map
      logic [IW-1:0] w_j;
      logic [IW-1:0] w_src;
      assign w_j = IW'(32'(r_count) * BITS_PER_CYCLE + 32'(g));
      bitrev_index_map #(.WIDTH(WIDTH)) u_map (
         .mode    (r_mode),
         .j       (w_j),
         .src_idx (w_src)
      );
      assign w_slice[g] = r_src[w_src];
   end

   always_comb begin
      w_next_result = r_result;
      w_next_result[32'(r_count) * BITS_PER_CYCLE +: BITS_PER_CYCLE] = w_slice;
   end

   assign w_last = (r_count == CW'(N - 1));

`ifdef BITREV_PALINDROME_EN
   logic r_palin;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_palin <= 1'b0;
      end else if (r_state == RUN && w_last) begin
         r_palin <= (w_next_result == r_src);
      end
   end
   assign out_palin = r_palin;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_src       <= '0;
         r_mode      <= MODE_BIT;
         r_result    <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_src      <= in_data;
                  r_mode     <= in_mode;
                  r_result   <= '0;
                  r_count    <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_result <= w_next_result;
               if (w_last) begin
                  r_out_data  <= w_next_result;
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            HOLD: begin
               // Handoff cycle returns to IDLE without accepting.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;

endmodule

// File: tb/tb_bitrev_engine.sv
// Scoreboard bench for bitrev_engine: an 8-bit/1-bpc and a 16-bit/4-bpc instance.
module tb_bitrev_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv8, ir8, ov8, or8, bsy8;
   logic [7:0]  id8, od8;
   logic [1:0]  im8;
   logic        iv16, ir16, ov16, or16, bsy16;
   logic [15:0] id16, od16;
   logic [1:0]  im16;
`ifdef BITREV_PALINDROME_EN
   logic        pal8, pal16;
`endif

   bitrev_engine #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
      .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(bsy8)
`ifdef BITREV_PALINDROME_EN
      , .out_palin(pal8)
`endif
   );

   bitrev_engine #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16), .in_mode(im16),
      .out_valid(ov16), .out_ready(or16), .out_data(od16), .busy(bsy16)
`ifdef BITREV_PALINDROME_EN
      , .out_palin(pal16)
`endif
   );

   typedef struct packed {
      logic [15:0] data;
      logic        palin;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   exp_t e8, e16;
   int   n_vec = 0;
   int   n_err = 0;
   int   drain_t;
   logic [7:0] snap;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitors: pop an expectation whenever a result handshake is about to happen.
   always @(negedge clk) begin
      if (!rst && ov8 && or8) begin
         if (q8.size() == 0) chk("unexpected_out8", 16'(od8), 16'hFFFF);
         else begin
            e8 = q8.pop_front();
            chk("out8", 16'(od8), e8.data);
`ifdef BITREV_PALINDROME_EN
            chk("palin8", 16'(pal8), 16'(e8.palin));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov16 && or16) begin
         if (q16.size() == 0) chk("unexpected_out16", od16, 16'hFFFF);
         else begin
            e16 = q16.pop_front();
            chk("out16", od16, e16.data);
`ifdef BITREV_PALINDROME_EN
            chk("palin16", 16'(pal16), 16'(e16.palin));
`endif
         end
      end
   end

   // Offer one word, push its expectation, then scramble the inputs after accept.
   task automatic run_job(input bit sel, input logic [15:0] d, input logic [1:0] m,
                          input logic [15:0] e, input bit push);
      int t = 0;
      @(negedge clk);
      while (!(sel ? ir16 : ir8) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sel) chk("ready16", 16'(ir16), 16'd1);
      else     chk("ready8", 16'(ir8), 16'd1);
      if (push) begin
         if (sel) q16.push_back('{e, (e == d)});
         else     q8.push_back('{e, (e == d)});
      end
      if (sel) begin iv16 = 1'b1; id16 = d;      im16 = m; end
      else     begin iv8  = 1'b1; id8  = d[7:0]; im8  = m; end
      @(posedge clk);
      #2;
      if (sel) begin iv16 = 1'b0; id16 = ~d;      im16 = m ^ 2'b01; end
      else     begin iv8  = 1'b0; id8  = ~d[7:0]; im8  = m ^ 2'b01; end
   endtask

   // Count edges from accept until out_valid; in_ready must stay low and busy high.
   task automatic check_latency(input bit sel, input int lat_exp);
      int   lat = 0;
      logic v   = 1'b0;
      logic bad = 1'b0;
      while (!v && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         v = sel ? ov16 : ov8;
         if ((sel ? ir16 : ir8) || !(sel ? bsy16 : bsy8)) bad = 1'b1;
      end
      chk("latency", 16'(lat), 16'(lat_exp));
      chk("run_flags", 16'(bad), 16'd0);
   endtask

   initial begin
      rst = 1'b1;
      iv8 = 1'b0; id8 = '0; im8 = '0; or8 = 1'b1;
      iv16 = 1'b0; id16 = '0; im16 = '0; or16 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst8", {5'd0, ov8, ir8, bsy8, od8}, {5'd0, 1'b0, 1'b1, 1'b0, 8'h00});
      chk("rst16", {13'd0, ov16, ir16, bsy16}, {13'd0, 1'b0, 1'b1, 1'b0});
      chk("rst16_data", od16, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      run_job(0, 16'h00CA, 2'd0, 16'h0053, 1); check_latency(0, 8);
      run_job(0, 16'h00B1, 2'd2, 16'h008D, 1); check_latency(0, 8);
      run_job(0, 16'h00C5, 2'd3, 16'h00C5, 1); check_latency(0, 8);
      run_job(0, 16'h0099, 2'd0, 16'h0099, 1); check_latency(0, 8);
      run_job(0, 16'h00CA, 2'd1, 16'h00CA, 1); check_latency(0, 8);

      run_job(1, 16'h12A4, 2'd1, 16'hA412, 1); check_latency(1, 4);
      run_job(1, 16'h0180, 2'd2, 16'h8001, 1); check_latency(1, 4);
      run_job(1, 16'hBEEF, 2'd3, 16'hBEEF, 1); check_latency(1, 4);
      run_job(1, 16'h0001, 2'd0, 16'h8000, 1); check_latency(1, 4);
      run_job(1, 16'h12A4, 2'd2, 16'h4825, 1); check_latency(1, 4);
      run_job(1, 16'h12A4, 2'd0, 16'h2548, 1); check_latency(1, 4);

      // Backpressure with a second word waiting on the input side.
      @(posedge clk);
      #2;
      or8 = 1'b0;
      run_job(0, 16'h0096, 2'd0, 16'h0069, 1); check_latency(0, 8);
      snap = od8;
      #1;
      iv8 = 1'b1; id8 = 8'h3A; im8 = 2'd0;
      q8.push_back('{16'h005C, 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold8", {5'd0, ov8, ir8, bsy8, od8}, {5'd0, 1'b1, 1'b0, 1'b1, snap});
      end
      @(posedge clk);
      #2;
      or8 = 1'b1;
      @(posedge clk);
      #1;
      chk("handoff8", {14'd0, ov8, ir8}, 16'd1);
      @(posedge clk);
      #2;
      iv8 = 1'b0;
      check_latency(0, 8);

      // Abort mid-job with reset, then run a fresh word.
      run_job(0, 16'h00AB, 2'd0, 16'h0000, 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_abort8", {5'd0, ov8, ir8, bsy8, od8}, {5'd0, 1'b0, 1'b1, 1'b0, 8'h00});
      @(negedge clk);
      rst = 1'b0;
      run_job(0, 16'h0001, 2'd0, 16'h0080, 1); check_latency(0, 8);

      drain_t = 0;
      while ((q8.size() + q16.size()) != 0 && drain_t < 100) begin
         @(posedge clk);
         drain_t++;
      end
      chk("drain", 16'(q8.size() + q16.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
